// File: rtl/pawn_move_checker_pkg.sv
// Shared piece encoding, move classes and checker FSM states for the pawn move checker.
package pawn_move_checker_pkg;

    typedef logic [3:0] piece_t;

    localparam piece_t     PIECE_EMPTY = 4'd15;
    localparam logic [2:0] PIECE_PAWN  = 3'd1;
    localparam int         COLOUR_BIT  = 3;

    typedef enum logic [1:0] {
        MV_ILLEGAL,
        MV_SINGLE,
        MV_DOUBLE,
        MV_DIAG
    } move_kind_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_MID,
        ST_RD_DEST,
        ST_EVAL,
        ST_RD_EP,
        ST_EVAL_EP,
        ST_DONE
    } state_t;

    // Colour bit is only meaningful for a non-empty square.
    function automatic logic piece_colour(piece_t p);
        return p[COLOUR_BIT];
    endfunction

    function automatic logic piece_is_pawn(piece_t p);
        return (p != PIECE_EMPTY) && (p[2:0] == PIECE_PAWN);
    endfunction

endpackage

// File: rtl/pawn_move_checker_if.sv
// Request, board read port and result bundle of the pawn move checker.
interface pawn_move_checker_if #(
    parameter int COORD_W = 3,
    parameter int PIECE_W = 4
);
    logic               valid_input;
    logic               ready;
    logic [COORD_W-1:0] old_x;
    logic [COORD_W-1:0] old_y;
    logic [COORD_W-1:0] new_x;
    logic [COORD_W-1:0] new_y;
    logic               mover_color;
    logic               ep_valid;
    logic [COORD_W-1:0] ep_x;
    logic               rd_en;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic [PIECE_W-1:0] rd_data;
    logic               valid_out;
    logic               valid_move;
    logic               is_double;
    logic               is_capture;
    logic               is_ep;
    logic               is_promo;

    modport master (
        output valid_input, old_x, old_y, new_x, new_y, mover_color, ep_valid, ep_x, rd_data,
        input  ready, rd_en, rd_x, rd_y, valid_out, valid_move, is_double, is_capture, is_ep, is_promo
    );

    modport slave (
        input  valid_input, old_x, old_y, new_x, new_y, mover_color, ep_valid, ep_x, rd_data,
        output ready, rd_en, rd_x, rd_y, valid_out, valid_move, is_double, is_capture, is_ep, is_promo
    );

endinterface

// File: rtl/pawn_move_checker_geom.sv
// Combinational pawn move geometry: move class, advance direction and the special ranks.
module pawn_move_checker_geom
    import pawn_move_checker_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM),
    parameter int FLIPPED   = 1
) (
    input  logic [COORD_W-1:0] old_x,
    input  logic [COORD_W-1:0] old_y,
    input  logic [COORD_W-1:0] new_x,
    input  logic [COORD_W-1:0] new_y,
    input  logic               mover_color,
    output move_kind_t         kind,
    output logic [COORD_W-1:0] mid_y,
    output logic [COORD_W-1:0] promo_rank,
    output logic [COORD_W-1:0] ep_rank
);

    localparam logic [COORD_W:0]        DIM = (COORD_W+1)'(BOARD_DIM);
    localparam logic signed [COORD_W:0] ONE = (COORD_W+1)'(1);

    logic                      fwd_neg;
    logic                      in_range;
    logic signed [COORD_W:0]   fwd;
    logic signed [COORD_W:0]   fwd2;
    logic signed [COORD_W:0]   dy;
    logic signed [COORD_W:0]   dx;
    logic signed [COORD_W:0]   adx;
    logic [COORD_W-1:0]        start_rank;

    always_comb begin
        fwd_neg    = (FLIPPED != 0) || !mover_color;
        fwd        = fwd_neg ? -ONE : ONE;
        fwd2       = fwd + fwd;
        dy         = $signed({1'b0, new_y}) - $signed({1'b0, old_y});
        dx         = $signed({1'b0, new_x}) - $signed({1'b0, old_x});
        adx        = (dx < 0) ? -dx : dx;
        start_rank = fwd_neg ? COORD_W'(BOARD_DIM - 2) : COORD_W'(1);
        promo_rank = fwd_neg ? '0 : COORD_W'(BOARD_DIM - 1);
        // start_rank + 3*fwd, the rank a capturing pawn stands on for en passant
        ep_rank    = fwd_neg ? COORD_W'(BOARD_DIM - 5) : COORD_W'(4);
        mid_y      = fwd_neg ? (old_y - COORD_W'(1)) : (old_y + COORD_W'(1));
        in_range   = ({1'b0, old_x} < DIM) && ({1'b0, old_y} < DIM) &&
                     ({1'b0, new_x} < DIM) && ({1'b0, new_y} < DIM);

        kind = MV_ILLEGAL;
        if (in_range) begin
            if (adx == '0 && dy == fwd) begin
                kind = MV_SINGLE;
            end else if (adx == '0 && dy == fwd2 && old_y == start_rank) begin
                kind = MV_DOUBLE;
            end else if (adx == ONE && dy == fwd) begin
                kind = MV_DIAG;
            end
        end
    end

endmodule

// File: rtl/pawn_move_checker.sv
// Multi-cycle pawn move validator; board squares are fetched through a 1-cycle-latency read port.
module pawn_move_checker
    import pawn_move_checker_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = $clog2(BOARD_DIM),
    parameter int PIECE_W   = 4,
    parameter int FLIPPED   = 1,
    parameter int EP_ENABLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    pawn_move_checker_if.slave bus
);

    localparam bit EP_ON = (EP_ENABLE != 0);

    state_t             state, state_nxt;
    logic [COORD_W-1:0] rd_x_q, rd_y_q, rd_x_nxt, rd_y_nxt;

    move_kind_t         kind, kind_q;
    logic [COORD_W-1:0] mid_y, promo_rank, ep_rank;
    logic [COORD_W-1:0] new_x_q, new_y_q, old_y_q, ep_x_q, promo_q, ep_rank_q;
    logic               color_q, ep_valid_q, mid_empty_q;

    logic               valid_move_q, is_double_q, is_capture_q, is_ep_q, is_promo_q;
    logic               accept, res_load, res_valid, res_cap, res_ep;
    logic               dest_empty, dest_enemy, ep_pawn, ep_try;
    piece_t             rd_piece;

    pawn_move_checker_geom #(
        .BOARD_DIM (BOARD_DIM),
        .COORD_W   (COORD_W),
        .FLIPPED   (FLIPPED)
    ) u_geom (
        .old_x       (bus.old_x),
        .old_y       (bus.old_y),
        .new_x       (bus.new_x),
        .new_y       (bus.new_y),
        .mover_color (bus.mover_color),
        .kind        (kind),
        .mid_y       (mid_y),
        .promo_rank  (promo_rank),
        .ep_rank     (ep_rank)
    );

    assign accept     = (state == ST_IDLE) && bus.valid_input;
    assign rd_piece   = piece_t'(bus.rd_data);
    assign dest_empty = (rd_piece == PIECE_EMPTY);
    assign dest_enemy = !dest_empty && (piece_colour(rd_piece) != color_q);
    assign ep_pawn    = piece_is_pawn(rd_piece) && (piece_colour(rd_piece) != color_q);
    assign ep_try     = EP_ON && (kind_q == MV_DIAG) && dest_empty && ep_valid_q &&
                        (ep_x_q == new_x_q) && (old_y_q == ep_rank_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            rd_x_q <= '0;
            rd_y_q <= '0;
        end else begin
            state  <= state_nxt;
            rd_x_q <= rd_x_nxt;
            rd_y_q <= rd_y_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_x_nxt  = rd_x_q;
        rd_y_nxt  = rd_y_q;
        res_load  = 1'b0;
        res_valid = 1'b0;
        res_cap   = 1'b0;
        res_ep    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.valid_input) begin
                    case (kind)
                        MV_ILLEGAL: state_nxt = ST_DONE;
                        MV_DOUBLE: begin
                            state_nxt = ST_RD_MID;
                            rd_x_nxt  = bus.old_x;
                            rd_y_nxt  = mid_y;
                        end
                        default: begin
                            state_nxt = ST_RD_DEST;
                            rd_x_nxt  = bus.new_x;
                            rd_y_nxt  = bus.new_y;
                        end
                    endcase
                end
            end
            ST_RD_MID: begin
                state_nxt = ST_RD_DEST;
                rd_x_nxt  = new_x_q;
                rd_y_nxt  = new_y_q;
            end
            ST_RD_DEST: state_nxt = ST_EVAL;
            // rd_data now holds the destination square
            ST_EVAL: begin
                if (ep_try) begin
                    state_nxt = ST_RD_EP;
                    rd_x_nxt  = new_x_q;
                    rd_y_nxt  = old_y_q;
                end else begin
                    state_nxt = ST_DONE;
                    res_load  = 1'b1;
                    case (kind_q)
                        MV_SINGLE: res_valid = dest_empty;
                        MV_DOUBLE: res_valid = dest_empty && mid_empty_q;
                        MV_DIAG: begin
                            res_valid = dest_enemy;
                            res_cap   = dest_enemy;
                        end
                        default: res_valid = 1'b0;
                    endcase
                end
            end
            ST_RD_EP: state_nxt = ST_EVAL_EP;
            ST_EVAL_EP: begin
                state_nxt = ST_DONE;
                res_load  = 1'b1;
                res_valid = ep_pawn;
                res_cap   = ep_pawn;
                res_ep    = ep_pawn;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            kind_q     <= kind;
            new_x_q    <= bus.new_x;
            new_y_q    <= bus.new_y;
            old_y_q    <= bus.old_y;
            color_q    <= bus.mover_color;
            ep_valid_q <= bus.ep_valid;
            ep_x_q     <= bus.ep_x;
            promo_q    <= promo_rank;
            ep_rank_q  <= ep_rank;
        end
        if (state == ST_RD_DEST) begin
            mid_empty_q <= dest_empty;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_move_q <= 1'b0;
            is_double_q  <= 1'b0;
            is_capture_q <= 1'b0;
            is_ep_q      <= 1'b0;
            is_promo_q   <= 1'b0;
        end else if (accept) begin
            valid_move_q <= 1'b0;
            is_double_q  <= 1'b0;
            is_capture_q <= 1'b0;
            is_ep_q      <= 1'b0;
            is_promo_q   <= 1'b0;
        end else if (res_load) begin
            valid_move_q <= res_valid;
            is_double_q  <= res_valid && (kind_q == MV_DOUBLE);
            is_capture_q <= res_valid && res_cap;
            is_ep_q      <= res_valid && res_ep;
            is_promo_q   <= res_valid && (new_y_q == promo_q);
        end
    end

    assign bus.ready      = (state == ST_IDLE);
    assign bus.rd_en      = (state == ST_RD_MID) || (state == ST_RD_DEST) || (state == ST_RD_EP);
    assign bus.rd_x       = rd_x_q;
    assign bus.rd_y       = rd_y_q;
    assign bus.valid_out  = (state == ST_DONE);
    assign bus.valid_move = valid_move_q;
    assign bus.is_double  = is_double_q;
    assign bus.is_capture = is_capture_q;
    assign bus.is_ep      = is_ep_q;
    assign bus.is_promo   = is_promo_q;

endmodule

// File: tb/tb_pawn_move_checker.sv
// Randomised and directed bench for pawn_move_checker: an 8x8 flipped instance and a 6x6 colour-directed one.
module tb_pawn_move_checker;

    localparam int CW = 3;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [CW-1:0] rq_ox = '0, rq_oy = '0, rq_nx = '0, rq_ny = '0, rq_epx = '0;
    logic          rq_col = 1'b0, rq_epv = 1'b0, vin0 = 1'b0, vin1 = 1'b0;
    logic [3:0]    board [8][8];
    logic          cur = 1'b0;

    pawn_move_checker_if #(.COORD_W(CW), .PIECE_W(PW)) if0 ();
    pawn_move_checker_if #(.COORD_W(CW), .PIECE_W(PW)) if1 ();

    assign if0.valid_input = vin0;
    assign if1.valid_input = vin1;
    assign if0.old_x = rq_ox;  assign if1.old_x = rq_ox;
    assign if0.old_y = rq_oy;  assign if1.old_y = rq_oy;
    assign if0.new_x = rq_nx;  assign if1.new_x = rq_nx;
    assign if0.new_y = rq_ny;  assign if1.new_y = rq_ny;
    assign if0.mover_color = rq_col;  assign if1.mover_color = rq_col;
    assign if0.ep_valid = rq_epv;     assign if1.ep_valid = rq_epv;
    assign if0.ep_x = rq_epx;         assign if1.ep_x = rq_epx;

    pawn_move_checker #(.BOARD_DIM(8), .COORD_W(CW), .PIECE_W(PW), .FLIPPED(1), .EP_ENABLE(1))
        dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    pawn_move_checker #(.BOARD_DIM(6), .COORD_W(CW), .PIECE_W(PW), .FLIPPED(0), .EP_ENABLE(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    // board memory: one cycle read latency for each instance
    always @(posedge clk) if (if0.rd_en) if0.rd_data <= board[if0.rd_x][if0.rd_y];
    always @(posedge clk) if (if1.rd_en) if1.rd_data <= board[if1.rd_x][if1.rd_y];

    wire          o_ready   = cur ? if1.ready      : if0.ready;
    wire          o_rd_en   = cur ? if1.rd_en      : if0.rd_en;
    wire [CW-1:0] o_rd_x    = cur ? if1.rd_x       : if0.rd_x;
    wire [CW-1:0] o_rd_y    = cur ? if1.rd_y       : if0.rd_y;
    wire          o_vout    = cur ? if1.valid_out  : if0.valid_out;
    wire          o_vmove   = cur ? if1.valid_move : if0.valid_move;
    wire          o_dbl     = cur ? if1.is_double  : if0.is_double;
    wire          o_cap     = cur ? if1.is_capture : if0.is_capture;
    wire          o_ep      = cur ? if1.is_ep      : if0.is_ep;
    wire          o_promo   = cur ? if1.is_promo   : if0.is_promo;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // reference model results
    int m_valid, m_dbl, m_cap, m_ep, m_promo, m_lat;
    int m_rx[$];
    int m_ry[$];
    // last observed results
    int r_lat, r_valid, r_dbl, r_cap, r_ep, r_promo, r_nrd, r_rx0, r_ry0;

    function automatic void model(input int dim, input int flipped, input int ox, input int oy,
                                  input int nx, input int ny, input int col, input int epv, input int epx);
        int fwd, start, prank, eprank, dy, adx;
        logic [3:0] d, m, e;
        m_valid = 0; m_dbl = 0; m_cap = 0; m_ep = 0; m_promo = 0; m_lat = 1;
        m_rx.delete(); m_ry.delete();
        fwd    = (flipped != 0 || col == 0) ? -1 : 1;
        start  = (fwd < 0) ? dim - 2 : 1;
        prank  = (fwd < 0) ? 0 : dim - 1;
        eprank = start + 3 * fwd;
        if (ox >= dim || oy >= dim || nx >= dim || ny >= dim) return;
        dy  = ny - oy;
        adx = (nx > ox) ? nx - ox : ox - nx;
        if (adx == 0 && dy == fwd) begin
            m_rx.push_back(nx); m_ry.push_back(ny); m_lat = 3;
            m_valid = (board[nx][ny] == 4'd15) ? 1 : 0;
        end else if (adx == 0 && dy == 2 * fwd && oy == start) begin
            m_rx.push_back(ox); m_ry.push_back(oy + fwd);
            m_rx.push_back(nx); m_ry.push_back(ny); m_lat = 4;
            m = board[ox][oy + fwd];
            d = board[nx][ny];
            m_valid = (m == 4'd15 && d == 4'd15) ? 1 : 0;
            m_dbl = m_valid;
        end else if (adx == 1 && dy == fwd) begin
            m_rx.push_back(nx); m_ry.push_back(ny); m_lat = 3;
            d = board[nx][ny];
            if (d != 4'd15) begin
                m_valid = (int'(d[3]) != col) ? 1 : 0;
                m_cap = m_valid;
            end else if (epv != 0 && epx == nx && oy == eprank) begin
                m_rx.push_back(nx); m_ry.push_back(oy); m_lat = 5;
                e = board[nx][oy];
                m_valid = (e != 4'd15 && e[2:0] == 3'd1 && int'(e[3]) != col) ? 1 : 0;
                m_cap = m_valid;
                m_ep = m_valid;
            end
        end
        m_promo = (m_valid != 0 && ny == prank) ? 1 : 0;
    endfunction

    task automatic clear_board();
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++)
                board[x][y] = 4'd15;
    endtask

    task automatic run_move(input int sel, input int ox, input int oy, input int nx, input int ny,
                            input int col, input int epv, input int epx, input bit hold, input string tag);
        int dim, fl, nex, nchk;
        int rx[$];
        int ry[$];
        bit seen;
        dim = (sel != 0) ? 6 : 8;
        fl  = (sel != 0) ? 0 : 1;
        model(dim, fl, ox, oy, nx, ny, col, epv, epx);
        cur = (sel != 0);
        @(negedge clk);
        rq_ox = CW'(ox); rq_oy = CW'(oy); rq_nx = CW'(nx); rq_ny = CW'(ny);
        rq_col = col[0]; rq_epv = epv[0]; rq_epx = CW'(epx);
        chk({tag, "_ready"}, int'(o_ready), 1);
        if (sel != 0) vin1 = 1'b1; else vin0 = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        r_lat = 0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (!hold) begin vin0 = 1'b0; vin1 = 1'b0; end
            if (o_vout) begin
                seen = 1'b1;
                r_lat = c;
            end else if (o_rd_en) begin
                rx.push_back(int'(o_rd_x));
                ry.push_back(int'(o_rd_y));
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
        r_valid = int'(o_vmove); r_dbl = int'(o_dbl); r_cap = int'(o_cap);
        r_ep = int'(o_ep); r_promo = int'(o_promo); r_nrd = rx.size();
        r_rx0 = (rx.size() > 0) ? rx[0] : -1;
        r_ry0 = (ry.size() > 0) ? ry[0] : -1;
        chk({tag, "_latency"}, r_lat, m_lat);
        chk({tag, "_valid_move"}, r_valid, m_valid);
        chk({tag, "_is_double"}, r_dbl, m_dbl);
        chk({tag, "_is_capture"}, r_cap, m_cap);
        chk({tag, "_is_ep"}, r_ep, m_ep);
        chk({tag, "_is_promo"}, r_promo, m_promo);
        chk({tag, "_reads"}, r_nrd, m_rx.size());
        nchk = (rx.size() < m_rx.size()) ? rx.size() : m_rx.size();
        for (int i = 0; i < nchk; i++) begin
            chk({tag, "_rd_x"}, rx[i], m_rx[i]);
            chk({tag, "_rd_y"}, ry[i], m_ry[i]);
        end
        vin0 = 1'b0; vin1 = 1'b0;
        nex = 0;
        for (int c = 0; c < (hold ? 6 : 1); c++) begin
            @(negedge clk);
            if (o_vout) nex++;
        end
        chk({tag, "_extra_valid_out"}, nex, 0);
        chk({tag, "_held"}, int'(o_vmove), m_valid);
    endtask

    initial begin
        int sel, dim, fwd, start, eprk, ox, oy, nx, ny, col, epv, epx, mode, t;
        clear_board();
        repeat (2) @(negedge clk);
        cur = 1'b0; #1;
        chk("reset0_ready", int'(o_ready), 1);
        chk("reset0_rd_en", int'(o_rd_en), 0);
        chk("reset0_valid_out", int'(o_vout), 0);
        chk("reset0_valid_move", int'(o_vmove), 0);
        cur = 1'b1; #1;
        chk("reset1_ready", int'(o_ready), 1);
        chk("reset1_valid_out", int'(o_vout), 0);
        @(negedge clk);
        reset = 1'b0;

        // single step
        run_move(0, 4, 6, 4, 5, 0, 0, 0, 1'b0, "single");
        chk("single_lat3", r_lat, 3); chk("single_ok", r_valid, 1);
        chk("single_one_read", r_nrd, 1); chk("single_rdx", r_rx0, 4); chk("single_rdy", r_ry0, 5);
        board[4][5] = 4'd2;
        run_move(0, 4, 6, 4, 5, 0, 0, 0, 1'b0, "single_block");
        chk("single_block_ok", r_valid, 0);
        clear_board();

        // double step
        run_move(0, 2, 6, 2, 4, 0, 0, 0, 1'b0, "double");
        chk("double_lat4", r_lat, 4); chk("double_ok", r_valid, 1); chk("double_flag", r_dbl, 1);
        board[2][5] = 4'd2;
        run_move(0, 2, 6, 2, 4, 0, 0, 0, 1'b0, "double_mid");
        chk("double_mid_ok", r_valid, 0);
        clear_board();
        run_move(0, 2, 5, 2, 3, 0, 0, 0, 1'b0, "double_bad_rank");
        chk("double_bad_lat1", r_lat, 1); chk("double_bad_reads", r_nrd, 0);

        // capture
        board[4][2] = 4'd12;
        run_move(0, 3, 3, 4, 2, 0, 0, 0, 1'b0, "capture");
        chk("capture_flag", r_cap, 1); chk("capture_ok", r_valid, 1);
        board[4][2] = 4'd4;
        run_move(0, 3, 3, 4, 2, 0, 0, 0, 1'b0, "capture_own");
        chk("capture_own_ok", r_valid, 0);
        clear_board();

        // en passant
        board[4][3] = 4'd9;
        run_move(0, 3, 3, 4, 2, 0, 1, 4, 1'b0, "ep");
        chk("ep_lat5", r_lat, 5); chk("ep_flag", r_ep, 1); chk("ep_cap", r_cap, 1);
        run_move(0, 3, 3, 4, 2, 0, 1, 5, 1'b0, "ep_wrong_file");
        chk("ep_wrong_lat3", r_lat, 3); chk("ep_wrong_ok", r_valid, 0);
        clear_board();

        // promotion, 6x6 colour-directed double, held request
        run_move(0, 0, 1, 0, 0, 0, 0, 0, 1'b0, "promo");
        chk("promo_flag", r_promo, 1);
        run_move(1, 1, 1, 1, 3, 1, 0, 0, 1'b0, "dim6_black_double");
        chk("dim6_double_flag", r_dbl, 1); chk("dim6_double_lat4", r_lat, 4);
        run_move(0, 4, 6, 4, 5, 0, 0, 0, 1'b1, "hold");

        // reset while the destination read is in flight
        cur = 1'b0;
        @(negedge clk);
        rq_ox = 3'd4; rq_oy = 3'd6; rq_nx = 3'd4; rq_ny = 3'd5; rq_col = 1'b0; rq_epv = 1'b0;
        vin0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vin0 = 1'b0;
        chk("rst_mid_pre_rd_en", int'(o_rd_en), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_rd_en", int'(o_rd_en), 0);
        chk("rst_mid_valid_out", int'(o_vout), 0);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_vout) t++;
        end
        chk("rst_mid_no_valid_out", t, 0);
        chk("rst_mid_ready", int'(o_ready), 1);

        // randomised moves on random boards
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 1));
            dim = (sel != 0) ? 6 : 8;
            col = int'($urandom_range(0, 1));
            fwd = (sel == 0 || col == 0) ? -1 : 1;
            start = (fwd < 0) ? dim - 2 : 1;
            eprk = start + 3 * fwd;
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++) begin
                    t = int'($urandom_range(0, 3));
                    board[x][y] = (t < 2) ? 4'd15
                                : {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
                end
            ox = int'($urandom_range(0, dim));
            oy = int'($urandom_range(0, dim - 1));
            nx = ox; ny = oy + fwd;
            epv = int'($urandom_range(0, 1));
            epx = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 4));
            case (mode)
                1: begin oy = start; ny = oy + 2 * fwd; end
                2: nx = ($urandom_range(0, 1) != 0) ? ox + 1 : ox - 1;
                3: begin
                    oy = eprk; ny = oy + fwd;
                    nx = ($urandom_range(0, 1) != 0) ? ox + 1 : ox - 1;
                    nx = nx & 7;
                    board[nx][ny & 7] = 4'd15;
                    if ($urandom_range(0, 3) != 0)
                        board[nx][oy] = {1'(1 - col), 3'd1};
                    epv = 1;
                    epx = ($urandom_range(0, 3) != 0) ? nx : int'($urandom_range(0, 7));
                end
                4: begin nx = int'($urandom_range(0, 7)); ny = int'($urandom_range(0, 7)); end
                default: ;
            endcase
            run_move(sel, ox & 7, oy & 7, nx & 7, ny & 7, col, epv, epx, 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
